// File: rtl/fir_stream_core.sv
// Streaming 11-tap FIR engine driving a read-only tap RAM and a circular data RAM.
// One sample in, eleven multiply-accumulates, one result out, under ap_start/ap_done control.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ap_start, ap_idle high
// CLEAR   | zeroing data words 0..NTAP-1
// WAIT_IN | ss_tready high, next sample written to data word wptr
// MAC     | NTAP read issues plus one trailing accumulate cycle
// OUT     | result held on the master stream until sm_tready
// DONE    | one-cycle ap_done pulse
module fir_stream_core #(
  parameter int NTAP       = 11,
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ap_start,
  input  logic [31:0]           data_length,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  ss_tvalid,
  input  logic [BIT_WIDTH-1:0]  ss_tdata,
  input  logic                  ss_tlast,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  output logic [BIT_WIDTH-1:0]  sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready,
  output logic                  tap_EN,
  output logic [3:0]            tap_WE,
  output logic [BIT_WIDTH-1:0]  tap_Di,
  output logic [ADDR_WIDTH-1:0] tap_A,
  input  logic [BIT_WIDTH-1:0]  tap_Do,
  output logic                  data_EN,
  output logic [3:0]            data_WE,
  output logic [BIT_WIDTH-1:0]  data_Di,
  output logic [ADDR_WIDTH-1:0] data_A,
  input  logic [BIT_WIDTH-1:0]  data_Do
);

  localparam int             KW        = 4;
  localparam logic [KW-1:0]  K_LAST    = KW'(NTAP - 1);
  localparam logic [KW-1:0]  K_ACC_END = KW'(NTAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          len_q, len_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        wptr_q, wptr_d;
  logic [31:0]          count_q, count_d;
  logic [BIT_WIDTH-1:0] acc_q, acc_d;
  logic                 ap_idle_q, ap_idle_d;
  logic                 ap_done_q, ap_done_d;
  logic                 ss_tready_q, ss_tready_d;
  logic                 sm_tvalid_q, sm_tvalid_d;
  logic [BIT_WIDTH-1:0] sm_tdata_q, sm_tdata_d;
  logic                 sm_tlast_q, sm_tlast_d;

  logic [KW-1:0]        rd_idx;
  logic [BIT_WIDTH-1:0] mac_prod;
  logic                 unused_ok;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [KW-1:0] idx);
    return {{(ADDR_WIDTH-KW-2){1'b0}}, idx, 2'b00};
  endfunction

  assign unused_ok = ss_tlast;

  // Newest sample pairs with tap 0; intermediate overflow of the wrap sum cancels mod 16.
  assign rd_idx = (wptr_q >= k_q) ? (wptr_q - k_q) : (wptr_q + K_ACC_END - k_q);

  // Low word of a two's-complement product equals the low word of the unsigned product.
  assign mac_prod = tap_Do * data_Do;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    k_d        = k_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    acc_d      = acc_q;
    sm_tdata_d = sm_tdata_q;
    sm_tlast_d = sm_tlast_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d   = data_length;
          k_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          wptr_d  = '0;
          count_d = '0;
          state_d = (len_q == 32'd0) ? S_DONE : S_WAIT_IN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_WAIT_IN: begin
        if (ss_tvalid && ss_tready_q) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (k_q != '0) begin
          acc_d = acc_q + mac_prod;
        end
        if (k_q == K_ACC_END) begin
          sm_tdata_d = acc_d;
          sm_tlast_d = (count_q == len_q - 32'd1);
          state_d    = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OUT: begin
        if (sm_tready) begin
          wptr_d  = (wptr_q == K_LAST) ? '0 : wptr_q + 1'b1;
          count_d = count_q + 32'd1;
          state_d = (count_q + 32'd1 == len_q) ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ap_idle_d   = (state_d == S_IDLE);
    ap_done_d   = (state_d == S_DONE);
    ss_tready_d = (state_d == S_WAIT_IN);
    sm_tvalid_d = (state_d == S_OUT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      k_q         <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      ap_idle_q   <= 1'b1;
      ap_done_q   <= 1'b0;
      ss_tready_q <= 1'b0;
      sm_tvalid_q <= 1'b0;
      sm_tdata_q  <= '0;
      sm_tlast_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      k_q         <= k_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      ap_idle_q   <= ap_idle_d;
      ap_done_q   <= ap_done_d;
      ss_tready_q <= ss_tready_d;
      sm_tvalid_q <= sm_tvalid_d;
      sm_tdata_q  <= sm_tdata_d;
      sm_tlast_q  <= sm_tlast_d;
    end
  end

  // RAM ports follow the current state; the sample write must land in its handshake cycle.
  always_comb begin
    tap_EN  = 1'b0;
    tap_A   = '0;
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;

    case (state_q)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(k_q);
      end
      S_WAIT_IN: begin
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = word_addr(wptr_q);
          data_Di = ss_tdata;
        end
      end
      S_MAC: begin
        if (k_q <= K_LAST) begin
          tap_EN  = 1'b1;
          tap_A   = word_addr(k_q);
          data_EN = 1'b1;
          data_A  = word_addr(rd_idx);
        end
      end
      default: begin
      end
    endcase

    if (RST) begin
      tap_EN  = 1'b0;
      tap_A   = '0;
      data_EN = 1'b0;
      data_WE = 4'h0;
      data_A  = '0;
      data_Di = '0;
    end
  end

  assign tap_WE    = 4'h0;
  assign tap_Di    = '0;
  assign ap_idle   = ap_idle_q;
  assign ap_done   = ap_done_q;
  assign ss_tready = ss_tready_q;
  assign sm_tvalid = sm_tvalid_q;
  assign sm_tdata  = sm_tdata_q;
  assign sm_tlast  = sm_tlast_q;

endmodule

// File: tb/tb_fir_stream_core.sv
// Directed bench for fir_stream_core with behavioural tap/data RAMs.
// Expected results are hand-computed constants for each scenario.
module tb_fir_stream_core;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_idle, ap_done;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;
  logic        tap_EN, data_EN;
  logic [3:0]  tap_WE, data_WE;
  logic [31:0] tap_Di, data_Di, tap_Do, data_Do;
  logic [11:0] tap_A, data_A;

  logic [31:0] tap_mem  [0:15];
  logic [31:0] data_mem [0:15];

  int tests = 0;
  int fails = 0;
  int data_wr_cnt = 0;
  int ss_hs_cnt = 0;
  int sm_hs_cnt = 0;

  always #5 CLK = ~CLK;

  fir_stream_core #(.NTAP(11), .ADDR_WIDTH(12), .BIT_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_EN(data_EN), .data_WE(data_WE), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  always @(posedge CLK) begin
    if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
    if (data_EN) data_Do <= data_mem[data_A[5:2]];
    if (data_EN && data_WE != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_mem[data_A[5:2]][8*b +: 8] <= data_Di[8*b +: 8];
      data_wr_cnt <= data_wr_cnt + 1;
    end
    if (ss_tvalid && ss_tready) ss_hs_cnt <= ss_hs_cnt + 1;
    if (sm_tvalid && sm_tready) sm_hs_cnt <= sm_hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic start_run(input logic [31:0] len);
    @(posedge CLK); #1;
    data_length = len;
    ap_start = 1'b1;
    @(posedge CLK); #1;
    ap_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    ss_tdata = d; ss_tlast = last; ss_tvalid = 1'b1;
    @(negedge CLK);
    while (!ss_tready && n < 100) begin @(negedge CLK); n++; end
    if (!ss_tready) chk("send_timeout", {31'b0, ss_tready}, 32'd1);
    @(posedge CLK); #1;
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] exp_d, input logic exp_last);
    int n = 0;
    @(negedge CLK);
    while (!sm_tvalid && n < 100) begin @(negedge CLK); n++; end
    chk({tag, "_valid"}, {31'b0, sm_tvalid}, 32'd1);
    chk(tag, sm_tdata, exp_d);
    chk({tag, "_last"}, {31'b0, sm_tlast}, {31'b0, exp_last});
    @(posedge CLK); #1;
  endtask

  task automatic check_done(input string tag);
    @(negedge CLK);
    chk({tag, "_done_hi"}, {31'b0, ap_done}, 32'd1);
    @(negedge CLK);
    chk({tag, "_done_lo"}, {31'b0, ap_done}, 32'd0);
    chk({tag, "_idle"}, {31'b0, ap_idle}, 32'd1);
  endtask

  task automatic run_impulse(input string pre);
    int wr0;
    for (int k = 0; k < 11; k++) tap_mem[k] = k + 1;
    wr0 = data_wr_cnt;
    start_run(32'd12);
    for (int n = 0; n < 12; n++) begin
      send((n == 0) ? 32'd1 : 32'd0, n == 11);
      recv($sformatf("%s_out%0d", pre, n), (n < 11) ? n + 1 : 0, n == 11);
    end
    check_done(pre);
    chk({pre, "_writes"}, data_wr_cnt - wr0, 32'd23);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    int wr0, ss0, sm0, n;
    RST = 1'b1; ap_start = 1'b0; data_length = 32'd0;
    ss_tvalid = 1'b0; ss_tdata = 32'd0; ss_tlast = 1'b0; sm_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin data_mem[i] = 32'hDEADBEEF; tap_mem[i] = 32'd0; end

    // reset values
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_idle", {31'b0, ap_idle}, 32'd1);
    chk("rst_done", {31'b0, ap_done}, 32'd0);
    chk("rst_ss_tready", {31'b0, ss_tready}, 32'd0);
    chk("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    chk("rst_sm_tdata", sm_tdata, 32'd0);
    chk("rst_sm_tlast", {31'b0, sm_tlast}, 32'd0);
    chk("rst_tap_en", {31'b0, tap_EN}, 32'd0);
    chk("rst_data_en", {31'b0, data_EN}, 32'd0);
    chk("rst_data_we", {28'b0, data_WE}, 32'd0);
    chk("rst_tap_we", {28'b0, tap_WE}, 32'd0);
    chk("rst_data_a", {20'b0, data_A}, 32'd0);
    chk("rst_tap_a", {20'b0, tap_A}, 32'd0);
    chk("rst_data_di", data_Di, 32'd0);

    // impulse
    run_impulse("imp");

    // constant input; mid-run length change is ignored
    for (int k = 0; k < 11; k++) tap_mem[k] = 32'd1;
    start_run(32'd15);
    data_length = 32'd3;
    for (int i = 0; i < 15; i++) begin
      send(32'd3, i == 14);
      recv($sformatf("const_out%0d", i), (i < 11) ? 3 * (i + 1) : 33, i == 14);
    end
    check_done("const");

    // signed arithmetic with backpressure on the first result
    for (int k = 0; k < 11; k++) tap_mem[k] = 32'hFFFFFFFE;
    sm_tready = 1'b0;
    start_run(32'd2);
    send(32'h7FFFFFFF, 1'b0);
    n = 0;
    @(negedge CLK);
    while (!sm_tvalid && n < 100) begin @(negedge CLK); n++; end
    wr0 = data_wr_cnt; sm0 = sm_hs_cnt;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), {31'b0, sm_tvalid}, 32'd1);
      chk($sformatf("bp_data%0d", i), sm_tdata, 32'h00000002);
      chk($sformatf("bp_ss_tready%0d", i), {31'b0, ss_tready}, 32'd0);
      @(negedge CLK);
    end
    chk("bp_no_writes", data_wr_cnt - wr0, 32'd0);
    chk("bp_no_hs", sm_hs_cnt - sm0, 32'd0);
    chk("bp_last", {31'b0, sm_tlast}, 32'd0);
    sm_tready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_hs", sm_hs_cnt - sm0, 32'd1);
    send(32'd1, 1'b1);
    recv("sig_out1", 32'h00000000, 1'b1);
    check_done("sig");

    // zero-length run
    wr0 = data_wr_cnt; ss0 = ss_hs_cnt; sm0 = sm_hs_cnt;
    start_run(32'd0);
    n = 0;
    @(negedge CLK);
    while (!ap_done && n < 50) begin @(negedge CLK); n++; end
    chk("len0_done", {31'b0, ap_done}, 32'd1);
    chk("len0_writes", data_wr_cnt - wr0, 32'd11);
    chk("len0_ss_hs", ss_hs_cnt - ss0, 32'd0);
    chk("len0_sm_hs", sm_hs_cnt - sm0, 32'd0);
    @(negedge CLK);
    chk("len0_done_lo", {31'b0, ap_done}, 32'd0);
    chk("len0_idle", {31'b0, ap_idle}, 32'd1);

    // reset during MAC tap 5, then a clean impulse run
    for (int k = 0; k < 11; k++) tap_mem[k] = k + 1;
    start_run(32'd12);
    send(32'd1, 1'b0);
    n = 0;
    @(negedge CLK);
    while (!(tap_EN && tap_A == 12'd20) && n < 50) begin @(negedge CLK); n++; end
    chk("rmac_reached_k5", {20'b0, tap_A}, 32'd20);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rmac_idle", {31'b0, ap_idle}, 32'd1);
    chk("rmac_tap_en", {31'b0, tap_EN}, 32'd0);
    chk("rmac_data_en", {31'b0, data_EN}, 32'd0);
    chk("rmac_data_we", {28'b0, data_WE}, 32'd0);
    chk("rmac_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    chk("rmac_ss_tready", {31'b0, ss_tready}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    run_impulse("imp2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
